// File: rtl/setpoint_ramp_pkg.sv
// Shared types and constants for the setpoint ramp sequencer.
//   - state_t   : playback FSM states
//   - segment_t : one ramp segment {target, step, dwell}, 44 bits
//   - accumulator is signed Q12.12; the setpoint is its integer part
package setpoint_ramp_pkg;

   localparam int SETPOINT_W   = 12;
   localparam int STEP_W       = 16;
   localparam int FRAC_BITS    = 12;
   localparam int SEG_DWELL_W  = 16;
   localparam int ACC_W        = SETPOINT_W + FRAC_BITS;
   localparam int ACC_XW       = ACC_W + 1;

   localparam int SETPOINT_MAX = 2047;
   localparam int SETPOINT_MIN = -2048;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RAMP  = 3'd2,
      DWELL = 3'd3,
      DONE  = 3'd4
   } state_t;

   typedef struct packed {
      logic signed [SETPOINT_W-1:0] target;
      logic        [STEP_W-1:0]     step;
      logic        [SEG_DWELL_W-1:0] dwell;
   } segment_t;

   localparam logic signed [ACC_W:0] ACC_HI =
      ACC_XW'((SETPOINT_MAX * (2 ** FRAC_BITS)) + (2 ** FRAC_BITS) - 1);
   localparam logic signed [ACC_W:0] ACC_LO =
      ACC_XW'(SETPOINT_MIN * (2 ** FRAC_BITS));

   function automatic logic signed [ACC_W-1:0] target_to_acc(
      input logic signed [SETPOINT_W-1:0] t);
      return {t, {FRAC_BITS{1'b0}}};
   endfunction

   // Bounds a one-bit-wider intermediate back into the Q12.12 range.
   function automatic logic signed [ACC_W-1:0] sat_acc(
      input logic signed [ACC_W:0] v);
      if (v > ACC_HI) begin
         return ACC_HI[ACC_W-1:0];
      end else if (v < ACC_LO) begin
         return ACC_LO[ACC_W-1:0];
      end else begin
         return v[ACC_W-1:0];
      end
   endfunction

endpackage

// File: rtl/setpoint_segment_ram.sv
// Segment table storage: NUM_SEG x segment_t, one write port, registered read.
// Contents are deliberately not reset.
//   clock      : system clock
//   i_wr_en    : write strobe
//   i_wr_addr  : write address
//   i_wr_data  : segment to store
//   i_rd_addr  : read address (sampled every cycle)
//   o_rd_data  : segment at i_rd_addr, one cycle later
module setpoint_segment_ram
   import setpoint_ramp_pkg::*;
#(
   parameter int NUM_SEG = 8,
   parameter int SEG_AW  = 3
) (
   input  logic              clock,
   input  logic              i_wr_en,
   input  logic [SEG_AW-1:0] i_wr_addr,
   input  segment_t          i_wr_data,
   input  logic [SEG_AW-1:0] i_rd_addr,
   output segment_t          o_rd_data
);

   segment_t r_mem [NUM_SEG];

   always_ff @(posedge clock) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
      o_rd_data <= r_mem[i_rd_addr];
   end

endmodule

// File: rtl/setpoint_ramp_sequencer.sv
// Setpoint ramp sequencer: plays back a table of {target, slew, dwell}
// segments and drives the 12-bit signed setpoint of the PID loop.
//
// Ports:
//   clock, reset          : system clock, async active-high reset
//   startIn / abortIn     : start playback at segment 0 / stop and hold
//   numSegmentsIn         : segments to play (0 -> 1), sampled at start
//   wrEnIn, wrAddrIn,
//   wrTargetIn, wrStepIn,
//   wrDwellIn             : table write port (accepted in IDLE/DONE only)
//   setpointOut           : integer part of the Q12.12 accumulator
//   busyOut, doneOut      : playback active / end-of-table pulse
//   segIndexOut           : segment currently executing
//   rampingOut            : high in RAMP
//   wrRejectOut           : pulse the cycle after a dropped write
//
// Build option: define SETPOINT_RAMP_LOOP_EN to wrap from the last segment
// back to segment 0 forever (doneOut pulses at each wrap).
//
// state | meaning
// IDLE  | waiting for startIn, setpoint held
// LOAD  | table read of segIndex in flight
// RAMP  | accumulator slewing toward target
// DWELL | holding target for dwell+1 cycles
// DONE  | last segment finished, doneOut high for this cycle
module setpoint_ramp_sequencer
   import setpoint_ramp_pkg::*;
#(
   parameter int NUM_SEG = 8,
   parameter int SEG_AW  = 3,
   parameter int DWELL_W = SEG_DWELL_W
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         startIn,
   input  logic                         abortIn,
   input  logic [SEG_AW:0]              numSegmentsIn,
   input  logic                         wrEnIn,
   input  logic [SEG_AW-1:0]            wrAddrIn,
   input  logic signed [SETPOINT_W-1:0] wrTargetIn,
   input  logic [STEP_W-1:0]            wrStepIn,
   input  logic [DWELL_W-1:0]           wrDwellIn,
   output logic signed [SETPOINT_W-1:0] setpointOut,
   output logic                         busyOut,
   output logic                         doneOut,
   output logic [SEG_AW-1:0]            segIndexOut,
   output logic                         rampingOut,
   output logic                         wrRejectOut
);

   localparam int CNT_W = SEG_AW + 1;

   state_t                  r_state;
   state_t                  w_next_state;
   logic signed [ACC_W-1:0] r_acc;
   logic [DWELL_W-1:0]      r_cnt;
   logic [SEG_AW-1:0]       r_seg_index;
   logic [SEG_AW:0]         r_num_seg;
   logic                    r_done;
   logic                    r_wr_reject;

   segment_t                w_wr_seg;
   segment_t                w_seg;
   logic                    w_wr_ok;
   logic                    w_wr_en;
   logic signed [ACC_W-1:0] w_tgt_acc;
   logic signed [ACC_W:0]   w_acc_ext;
   logic signed [ACC_W:0]   w_tgt_ext;
   logic signed [ACC_W:0]   w_step_ext;
   logic signed [ACC_W:0]   w_next_acc;
   logic                    w_up;
   logic                    w_reach;
   logic                    w_dwell_end;
   logic                    w_last;
   logic [SEG_AW:0]         w_seg_inc;
   logic [SEG_AW:0]         w_num_req;

   // Table writes only while no segment can be mid-read.
   assign w_wr_ok = (r_state == IDLE) || (r_state == DONE);
   assign w_wr_en = wrEnIn && w_wr_ok;

   always_comb begin
      w_wr_seg        = '0;
      w_wr_seg.target = wrTargetIn;
      w_wr_seg.step   = wrStepIn;
      w_wr_seg.dwell  = wrDwellIn;
   end

   // Read address is the live segment index; the registered output is
   // valid from the cycle after LOAD and stays put while the index is stable.
   setpoint_segment_ram #(
      .NUM_SEG (NUM_SEG),
      .SEG_AW  (SEG_AW)
   ) u_ram (
      .clock     (clock),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (wrAddrIn),
      .i_wr_data (w_wr_seg),
      .i_rd_addr (r_seg_index),
      .o_rd_data (w_seg)
   );

   // One guard bit so acc +/- step cannot wrap before the reach test.
   assign w_tgt_acc  = target_to_acc(w_seg.target);
   assign w_acc_ext  = {r_acc[ACC_W-1], r_acc};
   assign w_tgt_ext  = {w_tgt_acc[ACC_W-1], w_tgt_acc};
   assign w_step_ext = {{(ACC_XW - STEP_W){1'b0}}, w_seg.step};
   assign w_up       = w_tgt_ext > w_acc_ext;
   assign w_next_acc = w_up ? (w_acc_ext + w_step_ext) : (w_acc_ext - w_step_ext);
   assign w_reach    = (w_seg.step == '0) || (w_acc_ext == w_tgt_ext) ||
                       (w_up ? (w_next_acc >= w_tgt_ext) : (w_next_acc <= w_tgt_ext));

   assign w_dwell_end = (r_cnt == '0);
   assign w_seg_inc   = {1'b0, r_seg_index} + CNT_W'(1);
   assign w_last      = (w_seg_inc >= r_num_seg);

   always_comb begin
      w_num_req = numSegmentsIn;
      if (numSegmentsIn == '0) begin
         w_num_req = CNT_W'(1);
      end else if (numSegmentsIn > CNT_W'(NUM_SEG)) begin
         w_num_req = CNT_W'(NUM_SEG);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (startIn) begin
               w_next_state = LOAD;
            end
         end
         LOAD: begin
            w_next_state = abortIn ? IDLE : RAMP;
         end
         RAMP: begin
            if (abortIn) begin
               w_next_state = IDLE;
            end else if (w_reach) begin
               w_next_state = DWELL;
            end
         end
         DWELL: begin
            if (abortIn) begin
               w_next_state = IDLE;
            end else if (w_dwell_end) begin
               if (!w_last) begin
                  w_next_state = LOAD;
               end else begin
`ifdef SETPOINT_RAMP_LOOP_EN
                  w_next_state = LOAD;
`else
                  w_next_state = DONE;
`endif
               end
            end
         end
         DONE: begin
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_acc       <= '0;
         r_cnt       <= '0;
         r_seg_index <= '0;
         r_num_seg   <= CNT_W'(1);
         r_done      <= 1'b0;
         r_wr_reject <= 1'b0;
      end else begin
         r_wr_reject <= wrEnIn && !w_wr_ok;
         // Registered so it lines up with DONE, or with the wrap LOAD in loop mode.
         r_done      <= (r_state == DWELL) && !abortIn && w_dwell_end && w_last;
         case (r_state)
            IDLE: begin
               if (startIn) begin
                  r_seg_index <= '0;
                  r_num_seg   <= w_num_req;
               end
            end
            RAMP: begin
               if (!abortIn) begin
                  if (w_reach) begin
                     r_acc <= w_tgt_acc;
                     r_cnt <= w_seg.dwell;
                  end else begin
                     r_acc <= sat_acc(w_next_acc);
                  end
               end
            end
            DWELL: begin
               if (!abortIn) begin
                  if (w_dwell_end) begin
                     r_seg_index <= w_last ? '0 : w_seg_inc[SEG_AW-1:0];
                  end else begin
                     r_cnt <= r_cnt - DWELL_W'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      setpointOut = r_acc[ACC_W-1:FRAC_BITS];
      busyOut     = 1'b0;
      rampingOut  = 1'b0;
      doneOut     = r_done;
      segIndexOut = r_seg_index;
      wrRejectOut = r_wr_reject;
      case (r_state)
         LOAD:    busyOut = 1'b1;
         RAMP: begin
            busyOut    = 1'b1;
            rampingOut = 1'b1;
         end
         DWELL:   busyOut = 1'b1;
         default: busyOut = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_setpoint_ramp_sequencer.sv
module tb_setpoint_ramp_sequencer;

   localparam int NUM_SEG = 8;
   localparam int SEG_AW  = 3;
   localparam int DWELL_W = 16;
`ifdef SETPOINT_RAMP_LOOP_EN
   localparam bit LOOP_MODE = 1'b1;
`else
   localparam bit LOOP_MODE = 1'b0;
`endif

   logic                clock = 1'b0;
   logic                reset = 1'b1;
   logic                startIn = 1'b0;
   logic                abortIn = 1'b0;
   logic [SEG_AW:0]     numSegmentsIn = '0;
   logic                wrEnIn = 1'b0;
   logic [SEG_AW-1:0]   wrAddrIn = '0;
   logic signed [11:0]  wrTargetIn = '0;
   logic [15:0]         wrStepIn = '0;
   logic [DWELL_W-1:0]  wrDwellIn = '0;
   logic signed [11:0]  setpointOut;
   logic                busyOut;
   logic                doneOut;
   logic [SEG_AW-1:0]   segIndexOut;
   logic                rampingOut;
   logic                wrRejectOut;

   setpoint_ramp_sequencer #(
      .NUM_SEG (NUM_SEG),
      .SEG_AW  (SEG_AW),
      .DWELL_W (DWELL_W)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .startIn       (startIn),
      .abortIn       (abortIn),
      .numSegmentsIn (numSegmentsIn),
      .wrEnIn        (wrEnIn),
      .wrAddrIn      (wrAddrIn),
      .wrTargetIn    (wrTargetIn),
      .wrStepIn      (wrStepIn),
      .wrDwellIn     (wrDwellIn),
      .setpointOut   (setpointOut),
      .busyOut       (busyOut),
      .doneOut       (doneOut),
      .segIndexOut   (segIndexOut),
      .rampingOut    (rampingOut),
      .wrRejectOut   (wrRejectOut)
   );

   always #5 clock = ~clock;

   typedef struct {
      int sp;
      bit busy;
      bit ramp;
      bit done;
      int seg;   // -1: not checked
   } exp_t;

   exp_t   exp_q[$];
   int     tbl_tgt   [NUM_SEG];
   int     tbl_step  [NUM_SEG];
   int     tbl_dwell [NUM_SEG];
   longint m_acc = 0;   // reference accumulator, Q12.12 as a plain integer
   int     n_checks = 0;
   int     n_fail = 0;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      startIn = 1'b0;
      abortIn = 1'b0;
      wrEnIn  = 1'b0;
      reset   = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      m_acc = 0;
   endtask

   task automatic write_seg(input int a, input int t, input int s, input int d);
      wrEnIn     = 1'b1;
      wrAddrIn   = SEG_AW'(a);
      wrTargetIn = 12'(t);
      wrStepIn   = 16'(s);
      wrDwellIn  = DWELL_W'(d);
      tick();
      wrEnIn = 1'b0;
      n_checks++;
      if (wrRejectOut !== 1'b0) begin
         n_fail++;
         $display("FAIL write_accept addr=%0d: wrRejectOut=%0b expected 0", a, wrRejectOut);
      end
      tbl_tgt[a]   = t;
      tbl_step[a]  = s;
      tbl_dwell[a] = d;
   endtask

   // Expected per-cycle outputs from the first cycle after start, built from
   // the segment rules: one LOAD cycle, ramp cycles until the target is
   // reached or passed, dwell+1 hold cycles, then the end-of-table cycle.
   function automatic void build_trace(input int n);
      longint v;
      longint t;
      longint nxt;
      bit     hit;
      exp_q.delete();
      v = m_acc;
      for (int i = 0; i < n; i++) begin
         t = longint'(tbl_tgt[i]) * 4096;
         exp_q.push_back('{int'(v >>> 12), 1'b1, 1'b0, 1'b0, i});
         if (tbl_step[i] == 0 || v == t) begin
            exp_q.push_back('{int'(v >>> 12), 1'b1, 1'b1, 1'b0, i});
            v = t;
         end else begin
            hit = 1'b0;
            while (!hit) begin
               exp_q.push_back('{int'(v >>> 12), 1'b1, 1'b1, 1'b0, i});
               nxt = (v < t) ? v + tbl_step[i] : v - tbl_step[i];
               hit = (v < t) ? (nxt >= t) : (nxt <= t);
               v = hit ? t : nxt;
            end
         end
         for (int d = 0; d <= tbl_dwell[i]; d++) begin
            exp_q.push_back('{int'(v >>> 12), 1'b1, 1'b0, 1'b0, i});
         end
      end
      if (LOOP_MODE) begin
         exp_q.push_back('{int'(v >>> 12), 1'b1, 1'b0, 1'b1, 0});
      end else begin
         exp_q.push_back('{int'(v >>> 12), 1'b0, 1'b0, 1'b1, -1});
      end
      m_acc = v;
   endfunction

   task automatic run_playback(input int n_req, input bit start_abort, input string tag);
      exp_t e;
      int   n_eff;
      n_eff = (n_req == 0) ? 1 : n_req;
      build_trace(n_eff);
      numSegmentsIn = (SEG_AW+1)'(n_req);
      startIn = 1'b1;
      abortIn = start_abort;
      tick();
      startIn = 1'b0;
      abortIn = 1'b0;
      numSegmentsIn = (SEG_AW+1)'($urandom_range(0, 15));
      for (int k = 0; k < exp_q.size(); k++) begin
         e = exp_q[k];
         n_checks++;
         if (int'(setpointOut) !== e.sp) begin
            n_fail++;
            $display("FAIL %s setpoint cyc=%0d: got %0d expected %0d", tag, k + 1, setpointOut, e.sp);
         end
         n_checks++;
         if (busyOut !== e.busy) begin
            n_fail++;
            $display("FAIL %s busy cyc=%0d: got %0b expected %0b", tag, k + 1, busyOut, e.busy);
         end
         n_checks++;
         if (rampingOut !== e.ramp) begin
            n_fail++;
            $display("FAIL %s ramping cyc=%0d: got %0b expected %0b", tag, k + 1, rampingOut, e.ramp);
         end
         n_checks++;
         if (doneOut !== e.done) begin
            n_fail++;
            $display("FAIL %s done cyc=%0d: got %0b expected %0b", tag, k + 1, doneOut, e.done);
         end
         n_checks++;
         if (wrRejectOut !== 1'b0) begin
            n_fail++;
            $display("FAIL %s wrReject cyc=%0d: got %0b expected 0", tag, k + 1, wrRejectOut);
         end
         if (e.seg >= 0) begin
            n_checks++;
            if (int'(segIndexOut) !== e.seg) begin
               n_fail++;
               $display("FAIL %s segIndex cyc=%0d: got %0d expected %0d", tag, k + 1, segIndexOut, e.seg);
            end
         end
         if (k == 1) startIn = 1'b1;   // start while busy must be ignored
         if (k == exp_q.size() - 1) abortIn = LOOP_MODE;
         tick();
         startIn = 1'b0;
         abortIn = 1'b0;
      end
      n_checks++;
      if (busyOut !== 1'b0 || doneOut !== 1'b0 || rampingOut !== 1'b0) begin
         n_fail++;
         $display("FAIL %s idle_after: busy=%0b done=%0b ramping=%0b expected 0 0 0", tag, busyOut, doneOut, rampingOut);
      end
      n_checks++;
      if (int'(setpointOut) !== int'(m_acc >>> 12)) begin
         n_fail++;
         $display("FAIL %s held_setpoint: got %0d expected %0d", tag, setpointOut, int'(m_acc >>> 12));
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      n_checks++;
      if (setpointOut !== 12'sd0) begin n_fail++; $display("FAIL reset setpoint: got %0d expected 0", setpointOut); end
      n_checks++;
      if (busyOut !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %0b expected 0", busyOut); end
      n_checks++;
      if (doneOut !== 1'b0) begin n_fail++; $display("FAIL reset done: got %0b expected 0", doneOut); end
      n_checks++;
      if (segIndexOut !== '0) begin n_fail++; $display("FAIL reset segIndex: got %0d expected 0", segIndexOut); end
      n_checks++;
      if (rampingOut !== 1'b0) begin n_fail++; $display("FAIL reset ramping: got %0b expected 0", rampingOut); end
      n_checks++;
      if (wrRejectOut !== 1'b0) begin n_fail++; $display("FAIL reset wrReject: got %0b expected 0", wrRejectOut); end
      reset = 1'b0;
      tick();
      m_acc = 0;
   endtask

   task automatic test_single_ramp();
      apply_reset();
      write_seg(0, 100, 'h1000, 5);
      run_playback(1, 1'b0, "single_ramp");
   endtask

   task automatic test_neg_clamp();
      apply_reset();
      write_seg(0, -10, 'h3000, 0);
      run_playback(1, 1'b0, "neg_clamp");
   endtask

   task automatic test_two_jumps();
      write_seg(0, 2047, 0, 2);
      write_seg(1, -2048, 0, 0);
      run_playback(2, 1'b0, "two_jumps");
   endtask

   task automatic test_abort_reject();
      int guard;
      apply_reset();
      write_seg(0, 100, 'h1000, 0);
      numSegmentsIn = 1;
      startIn = 1'b1;
      tick();
      startIn = 1'b0;
      guard = 0;
      while (int'(setpointOut) != 20 && guard < 200) begin
         tick();
         guard++;
      end
      n_checks++;
      if (guard >= 200) begin n_fail++; $display("FAIL abort wait20: timeout, setpoint %0d expected 20", setpointOut); end
      wrEnIn     = 1'b1;
      wrAddrIn   = '0;
      wrTargetIn = -12'sd500;
      wrStepIn   = '0;
      wrDwellIn  = 3;
      tick();
      wrEnIn = 1'b0;
      n_checks++;
      if (wrRejectOut !== 1'b1) begin n_fail++; $display("FAIL reject_pulse: got %0b expected 1", wrRejectOut); end
      tick();
      n_checks++;
      if (wrRejectOut !== 1'b0) begin n_fail++; $display("FAIL reject_one_cycle: got %0b expected 0", wrRejectOut); end
      guard = 0;
      while (int'(setpointOut) != 40 && guard < 200) begin
         tick();
         guard++;
      end
      n_checks++;
      if (guard >= 200) begin n_fail++; $display("FAIL abort wait40: timeout, setpoint %0d expected 40", setpointOut); end
      abortIn = 1'b1;
      tick();
      abortIn = 1'b0;
      n_checks++;
      if (busyOut !== 1'b0) begin n_fail++; $display("FAIL abort busy: got %0b expected 0", busyOut); end
      n_checks++;
      if (setpointOut !== 12'sd40) begin n_fail++; $display("FAIL abort hold: got %0d expected 40", setpointOut); end
      n_checks++;
      if (doneOut !== 1'b0) begin n_fail++; $display("FAIL abort done: got %0b expected 0", doneOut); end
      tick();
      tick();
      n_checks++;
      if (setpointOut !== 12'sd40 || busyOut !== 1'b0) begin
         n_fail++;
         $display("FAIL abort stays: setpoint=%0d busy=%0b expected 40 0", setpointOut, busyOut);
      end
      m_acc = 40 * 4096;
      run_playback(1, 1'b0, "after_reject");
   endtask

   task automatic test_reset_mid_ramp();
      int guard;
      apply_reset();
      write_seg(0, 200, 'h1000, 0);
      numSegmentsIn = 1;
      startIn = 1'b1;
      tick();
      startIn = 1'b0;
      guard = 0;
      while (int'(setpointOut) != 57 && guard < 300) begin
         tick();
         guard++;
      end
      n_checks++;
      if (guard >= 300) begin n_fail++; $display("FAIL midreset wait57: timeout, setpoint %0d expected 57", setpointOut); end
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (setpointOut !== 12'sd0) begin n_fail++; $display("FAIL midreset setpoint: got %0d expected 0", setpointOut); end
      n_checks++;
      if (busyOut !== 1'b0) begin n_fail++; $display("FAIL midreset busy: got %0b expected 0", busyOut); end
      n_checks++;
      if (rampingOut !== 1'b0) begin n_fail++; $display("FAIL midreset ramping: got %0b expected 0", rampingOut); end
      n_checks++;
      if (segIndexOut !== '0) begin n_fail++; $display("FAIL midreset segIndex: got %0d expected 0", segIndexOut); end
      tick();
      reset = 1'b0;
      tick();
      n_checks++;
      if (busyOut !== 1'b0 || setpointOut !== 12'sd0) begin
         n_fail++;
         $display("FAIL midreset after: busy=%0b setpoint=%0d expected 0 0", busyOut, setpointOut);
      end
      m_acc = 0;
   endtask

   task automatic test_random();
      int n_req;
      for (int r = 0; r < 3; r++) begin
         for (int a = 0; a < NUM_SEG; a++) begin
            write_seg(a,
                      int'($urandom_range(0, 4095)) - 2048,
                      ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range('h1800, 'hFFFF)),
                      int'($urandom_range(0, 6)));
         end
         n_req = int'($urandom_range(0, 4));
         run_playback(n_req, (r == 1), "random");
      end
   endtask

`ifdef SETPOINT_RAMP_LOOP_EN
   task automatic test_loop();
      int  dones;
      int  guard;
      bit  busy_drop;
      apply_reset();
      write_seg(0, 5, 'h1000, 1);
      numSegmentsIn = 1;
      startIn = 1'b1;
      tick();
      startIn = 1'b0;
      dones = 0;
      guard = 0;
      busy_drop = 1'b0;
      while (dones < 3 && guard < 100) begin
         if (busyOut !== 1'b1) busy_drop = 1'b1;
         if (doneOut === 1'b1) dones++;
         if (dones < 3) tick();
         guard++;
      end
      n_checks++;
      if (dones != 3) begin n_fail++; $display("FAIL loop done_count: got %0d expected 3", dones); end
      n_checks++;
      if (busy_drop) begin n_fail++; $display("FAIL loop busy_held: busy dropped, expected 1 throughout"); end
      abortIn = 1'b1;
      tick();
      abortIn = 1'b0;
      n_checks++;
      if (busyOut !== 1'b0) begin n_fail++; $display("FAIL loop abort busy: got %0b expected 0", busyOut); end
      n_checks++;
      if (setpointOut !== 12'sd5) begin n_fail++; $display("FAIL loop abort hold: got %0d expected 5", setpointOut); end
      m_acc = 5 * 4096;
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_ramp();
      test_neg_clamp();
      test_two_jumps();
      test_abort_reject();
      test_reset_mid_ramp();
      test_random();
`ifdef SETPOINT_RAMP_LOOP_EN
      test_loop();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/setpoint_ramp_sequencer.md
Name: setpoint_ramp_sequencer

Overview:
- Generates the 12-bit signed setpoint consumed by the PID feedback loop's setpoint input, replacing the analog setpoint source when digital profiles are required.
- Plays back a host-loaded table of ramp segments. Each segment has a target, a slew rate and a dwell time.
- Sits between the host register interface and the PID block, in the same clock domain (64 MHz).

Parameters:
- NUM_SEG, 8, depth of the segment table (power of 2).
- SEG_AW, 3, table address width, log2(NUM_SEG).
- FRAC_BITS, 12, fractional bits of the internal setpoint accumulator.
- DWELL_W, 16, width of the dwell counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- startIn  in  1  pulse: begin playback at segment 0.
- abortIn  in  1  pulse: stop playback and hold the current setpoint.
- numSegmentsIn  in  SEG_AW+1  number of segments to play, 1..NUM_SEG; 0 is treated as 1.
- wrEnIn  in  1  table write strobe.
- wrAddrIn  in  SEG_AW  table write address.
- wrTargetIn  in  12  signed segment target.
- wrStepIn  in  16  unsigned slew per cycle, Q4.12; 0 means jump.
- wrDwellIn  in  DWELL_W  cycles to hold the target after reaching it.
- setpointOut  out  12  signed setpoint to PID.
- busyOut  out  1  playback in progress.
- doneOut  out  1  one-cycle pulse when the last segment's dwell ends.
- segIndexOut  out  SEG_AW  segment currently executing.
- rampingOut  out  1  high while in RAMP.
- wrRejectOut  out  1  one-cycle pulse when a write is dropped.

Behaviour:
- Reset values:
  - state IDLE; accumulator 0.
  - setpointOut 0, busyOut 0, doneOut 0, segIndexOut 0, rampingOut 0, wrRejectOut 0.
  - Table contents are not reset.
- Accumulator: 24-bit signed, Q12.12. setpointOut = acc[23:12], truncation toward −inf.
  - Targets are 12-bit and results are clamped, so overflow is impossible.
- Table writes:
  - Accepted only in IDLE or DONE; the written entry is visible to the next start.
  - A write in any other state is dropped and wrRejectOut pulses the following cycle.
- States:
  - IDLE: startIn → LOAD with segIndex=0 and busy=1. abortIn is ignored.
  - LOAD (1 cycle): registered table read of segIndex → RAMP.
  - RAMP, step=0: acc = target<<12 in one cycle, then → DWELL.
  - RAMP, otherwise: acc moves toward target by step each cycle. If the next value would reach or pass target, acc = target<<12 exactly and → DWELL.
  - RAMP, acc already equal to target: → DWELL without modification.
  - DWELL: counter loaded with dwell on entry, decrements each cycle. Exit when the counter reaches 0 (dwell=0 exits after 1 cycle).
    - If segIndex+1 < numSegments: segIndex++ and → LOAD.
    - Otherwise → DONE.
  - DONE: doneOut=1 for exactly this cycle, busy=0 → IDLE, setpoint held.
- Latency: startIn sampled at cycle 0; LOAD at 1; first RAMP at 2; first setpointOut change visible at cycle 3.
- Simultaneous events:
  - abortIn has priority over everything in LOAD, RAMP or DWELL. Next cycle → IDLE, busy=0, setpoint held at its current value, no doneOut.
  - startIn while busy is ignored.
  - startIn together with abortIn in IDLE: start wins.
- numSegmentsIn is sampled at start; later changes are ignored until the next start.
- Reset mid-operation: immediate return to reset values; setpointOut snaps to 0.

Optional Feature:
- Macro: SETPOINT_RAMP_LOOP_EN.
- Defined: after the last segment's dwell, the block re-enters LOAD at segIndex 0 instead of DONE. doneOut pulses at each wrap and busy stays high; only abortIn or reset stops playback.
- Undefined: single-shot behaviour as above.

Decomposition:
- Shared package setpoint_ramp_pkg holds:
  - state enum IDLE, LOAD, RAMP, DWELL, DONE;
  - SETPOINT_W=12, STEP_W=16, FRAC_BITS;
  - segment record type {target, step, dwell};
  - SETPOINT_MAX=2047, SETPOINT_MIN=−2048.
- One natural sub-module, setpoint_segment_ram:
  - NUM_SEG×44-bit storage;
  - single write port, registered read port;
  - no reset.

Test Plan:
- Reset asserted mid-ramp at setpoint 57 → setpointOut=0, busy=0, state IDLE within the same cycle (asynchronous).
- Table {100, 0x1000, 5}, numSegments=1, start at cycle 0 → setpointOut=1 at cycle 3, 100 at cycle 102, held ≥6 cycles, doneOut single pulse, busy low afterwards.
- Table {−10, 0x3000, 0} from 0 → setpointOut sequence 0, −3, −6, −9, −10 (clamped, no overshoot), then done.
- Two segments {2047, 0, 2} and {−2048, 0, 0} → setpointOut jumps to 2047 at cycle 3, then to −2048; segIndexOut goes 0→1; one doneOut.
- abortIn while RAMP at setpoint 40 → next cycle busy=0, setpointOut stays 40, no doneOut. A write during RAMP → wrRejectOut pulses and the entry is unchanged when read back on the next run.
- With SETPOINT_RAMP_LOOP_EN: 1 segment {5, 0x1000, 1}, 3 wraps → doneOut pulses 3 times, busy stays 1 until abortIn.
